// File: rtl/gcd_euclid.sv
// Euclidean GCD sequencer driving a shift-subtract modulus unit over run/ready.
// Optional RUN-state abort: define GCD_TIMEOUT_EN to enable the TIMEOUT watchdog.
module gcd_euclid #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 4096,
    parameter int ICW     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd,
    output logic [ICW-1:0]   iter_count,
    output logic             err,
    output logic             mod_run,
    output logic [WIDTH-1:0] mod_a,
    output logic [WIDTH-1:0] mod_b,
    input  logic [WIDTH-1:0] mod_result,
    input  logic             mod_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DROP,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;

    generate
        if (TIMEOUT < 2) begin : g_timeout_too_small
        end
    endgenerate

`ifdef GCD_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT);
    logic [TCW-1:0] tcnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            a          <= '0;
            b          <= '0;
            r          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            gcd        <= '0;
            iter_count <= '0;
            err        <= 1'b0;
            mod_run    <= 1'b0;
            mod_a      <= '0;
            mod_b      <= '0;
`ifdef GCD_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a          <= A;
                        b          <= B;
                        iter_count <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // A zero divisor is resolved here; the modulus unit would hang on it.
                    if (b == '0) begin
                        gcd   <= a;
                        done  <= 1'b1;
                        if (a == '0) begin
                            err <= 1'b1;
                        end
                        state <= S_DONE;
                    end else begin
                        mod_run <= 1'b1;
                        mod_a   <= a;
                        mod_b   <= b;
                        if (iter_count != '1) begin
                            iter_count <= iter_count + 1'b1;
                        end
`ifdef GCD_TIMEOUT_EN
                        tcnt    <= '0;
`endif
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (mod_ready) begin
                        r       <= mod_result;
                        mod_run <= 1'b0;
                        state   <= S_DROP;
                    end
`ifdef GCD_TIMEOUT_EN
                    else if (tcnt == TCW'(TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        mod_run <= 1'b0;
                        gcd     <= '0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                S_DROP: begin
                    a     <= b;
                    b     <= r;
                    state <= S_CHECK;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
